// File: rtl/track_seq_pkg.sv
// Shared constants and state encoding for the track record/playback sequencer.
package track_seq_pkg;

    localparam int NOTE_W      = 27;
    localparam int ADDR_W      = 12;
    localparam int NUM_TRACKS  = 5;
    localparam int TRK_W       = 3;
    localparam int TRACK_DEPTH = 512;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_PLAY = 2'b01;
    localparam logic [1:0] ST_REC  = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_PLAY = ST_PLAY,
        S_REC  = ST_REC
    } seq_state_e;

endpackage

// File: rtl/btn_edge_prio.sv
// Rising-edge detector for the track buttons; reports the lowest-index rising bit.
module btn_edge_prio #(
    parameter int NUM   = 5,
    parameter int IDX_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NUM-1:0]   btn,
    output logic             edge_vld,
    output logic [IDX_W-1:0] edge_idx
);

    logic [NUM-1:0] btn_q;
    logic [NUM-1:0] rise;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) btn_q <= '0;
        else        btn_q <= btn;
    end

    assign rise     = btn & ~btn_q;
    assign edge_vld = |rise;

    // Scan high to low so the lowest rising index is the one left standing.
    always_comb begin
        edge_idx = '0;
        for (int i = NUM - 1; i >= 0; i--) begin
            if (rise[i]) edge_idx = IDX_W'(i);
        end
    end

endmodule

// File: rtl/track_sequencer.sv
// Record/playback sequencer in front of the note memory, five fixed tracks.
// Define TRACK_SEQ_LOOP_EN to make playback loop at end of track instead of stopping.
module track_sequencer #(
    parameter int NOTE_W      = track_seq_pkg::NOTE_W,
    parameter int ADDR_W      = track_seq_pkg::ADDR_W,
    parameter int TRACK_DEPTH = track_seq_pkg::TRACK_DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tick,
    input  logic [4:0]        btn,
    input  logic              rec_sw,
    input  logic [NOTE_W-1:0] key,
    input  logic [NOTE_W-1:0] mem_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [NOTE_W-1:0] mem_wdata,
    output logic [NOTE_W-1:0] note,
    output logic [1:0]        state,
    output logic [2:0]        track
);
    import track_seq_pkg::*;

    localparam int OFF_W = $clog2(TRACK_DEPTH);
    localparam int LEN_W = OFF_W + 1;

    seq_state_e                           st_q;
    logic [TRK_W-1:0]                     trk_q;
    logic [OFF_W-1:0]                     off_q;
    logic [NUM_TRACKS-1:0][LEN_W-1:0]     len_q;
    logic                                 rec_q;
    logic [NOTE_W-1:0]                    note_q;

    logic                                 edge_vld;
    logic [TRK_W-1:0]                     edge_idx;
    logic [LEN_W-1:0]                     off_inc;
    logic [LEN_W-1:0]                     cur_len;
    logic                                 rec_fall;

    btn_edge_prio #(
        .NUM   (NUM_TRACKS),
        .IDX_W (TRK_W)
    ) u_btn (
        .clk      (clk),
        .reset    (reset),
        .btn      (btn),
        .edge_vld (edge_vld),
        .edge_idx (edge_idx)
    );

    assign off_inc  = LEN_W'(off_q) + LEN_W'(1);
    assign cur_len  = len_q[trk_q];
    assign rec_fall = rec_q & ~rec_sw;

    // A button edge steals the tick of the same clk, so the write is suppressed too.
    assign mem_we    = (st_q == S_REC) && tick && !edge_vld;
    assign mem_wdata = key;
    assign mem_addr  = (ADDR_W'(trk_q) << OFF_W) | ADDR_W'(off_q);
    assign state     = st_q;
    assign track     = trk_q;

    always_comb begin
        note = '0;
        case (st_q)
            S_REC:   note = key;
            S_PLAY:  note = note_q;
            default: note = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st_q   <= S_IDLE;
            trk_q  <= '0;
            off_q  <= '0;
            len_q  <= '0;
            rec_q  <= 1'b0;
            note_q <= '0;
        end else begin
            rec_q  <= rec_sw;
            note_q <= mem_rdata;
            if (edge_vld) begin
                if (rec_sw) begin
                    st_q            <= S_REC;
                    trk_q           <= edge_idx;
                    off_q           <= '0;
                    len_q[edge_idx] <= '0;
                end else if (st_q == S_PLAY && edge_idx == trk_q) begin
                    st_q <= S_IDLE;
                end else if (len_q[edge_idx] != '0) begin
                    st_q  <= S_PLAY;
                    trk_q <= edge_idx;
                    off_q <= '0;
                end else begin
                    st_q  <= S_IDLE;
                    trk_q <= edge_idx;
                end
            end else begin
                case (st_q)
                    S_REC: begin
                        // Offset wraps to 0 naturally when the track fills.
                        if (tick) begin
                            off_q        <= off_q + 1'b1;
                            len_q[trk_q] <= off_inc;
                            if (off_inc == LEN_W'(TRACK_DEPTH)) st_q <= S_IDLE;
                        end
                        if (rec_fall) st_q <= S_IDLE;
                    end
                    S_PLAY: begin
                        if (tick) begin
                            if (off_inc == cur_len) begin
                                off_q <= '0;
`ifdef TRACK_SEQ_LOOP_EN
                                st_q  <= S_PLAY;
`else
                                st_q  <= S_IDLE;
`endif
                            end else begin
                                off_q <= off_q + 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_track_sequencer.sv
// Scoreboard bench for track_sequencer: directed stimulus queues expected writes and snapshots.
module tb_track_sequencer;

    localparam int NW = 27;
    localparam int AW = 12;
    localparam logic [1:0] SI = 2'b00, SP = 2'b01, SR = 2'b10;

    logic          clk = 1'b0, reset = 1'b0, tick = 1'b0, rec_sw = 1'b0;
    logic [4:0]    btn = '0;
    logic [NW-1:0] key = '0, mem_rdata = '0;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [NW-1:0] mem_wdata, note;
    logic [1:0]    state;
    logic [2:0]    track;

    always #5 clk = ~clk;

    track_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .tick      (tick),
        .btn       (btn),
        .rec_sw    (rec_sw),
        .key       (key),
        .mem_rdata (mem_rdata),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .note      (note),
        .state     (state),
        .track     (track)
    );

    logic [NW-1:0] mem [4096];
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    typedef struct {
        logic [AW-1:0] addr;
        logic [NW-1:0] data;
    } wr_t;

    typedef struct {
        int            id;
        logic [1:0]    st;
        logic [2:0]    trk;
        logic [NW-1:0] nt;
        logic          chk_nt;
        logic [AW-1:0] addr;
    } snap_t;

    wr_t   wq[$];
    snap_t sq[$];
    wr_t   mw;
    snap_t ms;
    int    n_vec = 0, n_err = 0, snap_id = 0;
    logic  chk_req = 1'b0, fin_req = 1'b0, fin_done = 1'b0;

    // Monitor: every write pulse pops an expected write; every snapshot request pops a snapshot.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            n_vec++;
            if (wq.size() == 0) begin
                n_err++;
                $display("FAIL write_unexpected got addr=%0d data=%h want no write", mem_addr, mem_wdata);
            end else begin
                mw = wq.pop_front();
                if (mem_addr !== mw.addr || mem_wdata !== mw.data) begin
                    n_err++;
                    $display("FAIL write got addr=%0d data=%h want addr=%0d data=%h",
                             mem_addr, mem_wdata, mw.addr, mw.data);
                end
            end
        end
        if (chk_req) begin
            if (sq.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL snap_queue got empty want entry");
            end else begin
                ms = sq.pop_front();
                n_vec += 4;
                if (state !== ms.st) begin
                    n_err++; $display("FAIL snap%0d state got %0d want %0d", ms.id, state, ms.st);
                end
                if (track !== ms.trk) begin
                    n_err++; $display("FAIL snap%0d track got %0d want %0d", ms.id, track, ms.trk);
                end
                if (mem_addr !== ms.addr) begin
                    n_err++; $display("FAIL snap%0d addr got %0d want %0d", ms.id, mem_addr, ms.addr);
                end
                if (mem_we !== 1'b0) begin
                    n_err++; $display("FAIL snap%0d we got %b want 0", ms.id, mem_we);
                end
                if (ms.chk_nt) begin
                    n_vec++;
                    if (note !== ms.nt) begin
                        n_err++; $display("FAIL snap%0d note got %h want %h", ms.id, note, ms.nt);
                    end
                end
            end
        end
        if (fin_req && !fin_done) begin
            n_vec += 2;
            if (wq.size() != 0) begin
                n_err++; $display("FAIL writes_missing got %0d pending want 0", wq.size());
            end
            if (sq.size() != 0) begin
                n_err++; $display("FAIL snaps_missing got %0d pending want 0", sq.size());
            end
            fin_done = 1'b1;
        end
    end

    task automatic clk1();
        @(posedge clk);
        #1;
        tick    = 1'b0;
        chk_req = 1'b0;
    endtask

    task automatic do_tick();
        tick = 1'b1;
        clk1();
    endtask

    task automatic exp_wr(input logic [AW-1:0] a, input logic [NW-1:0] d);
        wr_t w;
        w.addr = a;
        w.data = d;
        wq.push_back(w);
    endtask

    task automatic snap(input logic [1:0] st, input logic [2:0] trk, input logic [NW-1:0] nt,
                        input logic chk_nt, input logic [AW-1:0] a, input logic tk);
        snap_t s;
        s.id = snap_id; s.st = st; s.trk = trk; s.nt = nt; s.chk_nt = chk_nt; s.addr = a;
        snap_id++;
        sq.push_back(s);
        tick    = tk;
        chk_req = 1'b1;
        clk1();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    logic [NW-1:0] dat [3];
    logic [1:0]    e_st;
    logic [AW-1:0] e_a;
    logic [NW-1:0] e_nt;

    initial begin
        dat[0] = 27'h0123456; dat[1] = 27'h0654321; dat[2] = 27'h7ABCDEF;
        repeat (3) clk1();
        reset = 1'b1;
        clk1();

        // Record on track 0, then assert reset in the middle of it.
        rec_sw = 1'b1; btn = 5'b00001; clk1();
        for (int i = 0; i < 37; i++) begin
            key = 27'(100 + i);
            exp_wr(12'(i), key);
            do_tick();
        end
        key = 27'h1ABCDEF;
        snap(SR, 3'd0, key, 1'b1, 12'd37, 1'b0);
        reset = 1'b0;
        snap(SI, 3'd0, '0, 1'b1, 12'd0, 1'b1);
        clk1();
        btn = '0; rec_sw = 1'b0; clk1();
        reset = 1'b1; clk1();
        btn = 5'b00001; clk1();
        snap(SI, 3'd0, '0, 1'b1, 12'd0, 1'b0);

        // Record A,B,C on track 2.
        btn = '0; clk1();
        key = dat[0]; rec_sw = 1'b1; btn = 5'b00100; clk1();
        snap(SR, 3'd2, dat[0], 1'b1, 12'd1024, 1'b0);
        for (int k = 0; k < 3; k++) begin
            key = dat[k];
            exp_wr(12'(1024 + k), dat[k]);
            do_tick();
        end
        rec_sw = 1'b0; clk1();
        snap(SI, 3'd2, '0, 1'b1, 12'd1027, 1'b0);

        // Play track 2; each snapshot sits two clk after the address settled.
        btn = '0; clk1();
        btn = 5'b00100; clk1();
        for (int k = 0; k < 8; k++) begin
            clk1(); clk1();
`ifdef TRACK_SEQ_LOOP_EN
            e_st = SP; e_a = 12'(1024 + k % 3); e_nt = dat[k % 3];
`else
            if (k < 3) begin
                e_st = SP; e_a = 12'(1024 + k); e_nt = dat[k];
            end else begin
                e_st = SI; e_a = 12'd1024; e_nt = '0;
            end
`endif
            snap(e_st, 3'd2, e_nt, 1'b1, e_a, (k < 7) ? 1'b1 : 1'b0);
        end

        // Simultaneous btn[1]/btn[3] edge with a tick while recording track 0.
        btn = '0; clk1();
        rec_sw = 1'b1; btn = 5'b00001; clk1();
        btn = '0; clk1();
        key = 27'h2468ACE; btn = 5'b01010; tick = 1'b1; clk1();
        snap(SR, 3'd1, key, 1'b1, 12'd512, 1'b0);
        rec_sw = 1'b0; clk1();
        btn = '0; clk1();

        // Fill track 4 completely, then one extra tick.
        rec_sw = 1'b1; btn = 5'b10000; clk1();
        for (int i = 0; i < 512; i++) begin
            key = 27'(i * 7 + 3);
            exp_wr(12'(2048 + i), key);
            do_tick();
        end
        snap(SI, 3'd4, '0, 1'b1, 12'd2048, 1'b0);
        key = 27'h3FFFFFF;
        do_tick();

        // Play it back to confirm len[4] = 512.
        rec_sw = 1'b0; btn = '0; clk1();
        btn = 5'b10000; clk1();
        for (int i = 0; i < 511; i++) do_tick();
        snap(SP, 3'd4, 27'(509 * 7 + 3), 1'b1, 12'd2559, 1'b0);
        do_tick();
`ifdef TRACK_SEQ_LOOP_EN
        snap(SP, 3'd4, 27'(511 * 7 + 3), 1'b1, 12'd2048, 1'b0);
`else
        snap(SI, 3'd4, '0, 1'b1, 12'd2048, 1'b0);
`endif

        // Track 2 still plays, second press stops it, empty track 0 stays idle.
        btn = '0; clk1();
        btn = 5'b00100; clk1();
        snap(SP, 3'd2, '0, 1'b0, 12'd1024, 1'b0);
        btn = '0; clk1();
        btn = 5'b00100; clk1();
        snap(SI, 3'd2, '0, 1'b1, 12'd1024, 1'b0);
        btn = '0; clk1();
        btn = 5'b00001; clk1();
        snap(SI, 3'd0, '0, 1'b1, 12'd0, 1'b0);

        fin_req = 1'b1;
        clk1(); clk1();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
